cnt_ctrl: RTL and testbench
===========================

// Module: cnt_ctrl
// PURPOSE
//  Upstream command stage for the 4-bit up/down counter (cnt). Turns raw board buttons and
//  switches into clean single-cycle cnt controls: en/up for counting, load/count_in for preset.
//  Synchronizes and debounces each button, edge-detects presses, auto-repeats held up/down.
//  Outputs wire directly to cnt's en, up, load, count_in inputs.
// PARAMETERS
//  WIDTH           4        width of sw/count_in; matches cnt count width
//  DEBOUNCE_CYCLES 500000   consecutive stable synced samples needed to accept a level (5 ms @100 MHz)
//  HOLD_CYCLES     50000000 cycles a direction button is held before auto-repeat starts; 0 = no repeat
//  REPEAT_CYCLES   10000000 cycles between auto-repeat pulses once repeating (>=1)
// PORTS
//  clk       in   1      system clock; the only clock
//  rst       in   1      reset, synchronous, active-high
//  btn_up    in   1      raw async button: count up
//  btn_down  in   1      raw async button: count down
//  btn_load  in   1      raw async button: load sw into counter
//  sw        in   WIDTH  raw switches, preset value
//  en        out  1      one-cycle count-enable pulse to cnt
//  up        out  1      direction to cnt (1=up); holds last issued direction
//  load      out  1      one-cycle load pulse to cnt
//  count_in  out  WIDTH  registered preset value for cnt
// BEHAVIOUR
//  - Reset: en=0, up=0, load=0, count_in=0; sync flops, debounced levels, counters, FSM -> 0/IDLE.
//  - Each button: 2-flop synchronizer; debounce counter increments while synced != debounced,
//    clears when equal; debounced toggles when counter reaches DEBOUNCE_CYCLES-1 with mismatch.
//    Rise pulse = debounced & ~debounced_q (one cycle). Release has same debounce, no pulse.
//  - sw: 2-flop synchronized, not debounced; count_in loads synced sw on the cycle load=1 only.
//  - Latency: clean press first sampled high at edge N -> en/load high for exactly one cycle
//    at edge N+DEBOUNCE_CYCLES+3. All outputs registered.
//  - Command arbitration per cycle, priority load > up > down. en and load never both 1.
//    Losing rise pulses are dropped (not queued).
//  - Repeat FSM (shared by up/down), states IDLE, HOLD, REPEAT, register dir:
//      IDLE:   winning up/down rise -> issue en, dir=that button, timer=0, -> HOLD
//      HOLD:   timer++; timer==HOLD_CYCLES-1 -> issue en (same dir), timer=0, -> REPEAT
//      REPEAT: timer++; timer==REPEAT_CYCLES-1 -> issue en, timer=0
//      any non-IDLE: debounced[dir]==0 -> IDLE (same cycle, no pulse)
//    HOLD_CYCLES==0: HOLD never exits except by release. Other direction's press
//    while not IDLE is ignored. Load pulse while HOLD/REPEAT: load issued, FSM timer keeps running;
//    a repeat en colliding with load is dropped that cycle.
//  - up updates only when en issued; load never changes up.
//  - Reset mid-operation: everything clears; a button still held after rst drops is seen as a
//    new press (debounced=0, input 1) and produces one pulse after full latency.
//  - Glitch shorter than DEBOUNCE_CYCLES: no output change.
// STRUCTURE
//  - Package cnt_ctrl_pkg: typedef enum logic [1:0] {CMD_NONE, CMD_UP, CMD_DOWN, CMD_LOAD} cmd_t;
//    typedef enum logic [1:0] {RPT_IDLE, RPT_HOLD, RPT_REPEAT} rpt_state_t.
//  - Sub-module btn_debounce (sync + debounce + rise pulse; params DEBOUNCE_CYCLES),
//    instantiated 3x. Arbiter, repeat FSM, output regs in cnt_ctrl.
// TESTING  (DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, REPEAT_CYCLES=3, WIDTH=4)
//  - Reset: rst=1 for 4 cycles with all buttons high -> all outputs 0; release rst, hold
//    btn_up -> one en with up=1 at DEBOUNCE_CYCLES+3 after first sample.
//  - Debounce: btn_down pulses high 3 cycles, low, repeated -> en never 1; then held 6 cycles
//    -> one en, up=0.
//  - Load: sw=4'hA, tap btn_load 10 cycles -> load=1 one cycle, count_in=4'hA, en=0; sw->4'h3
//    afterwards -> count_in stays 4'hA.
//  - Auto-repeat: hold btn_up 30 cycles -> en at press, +8, then every 3 cycles; release ->
//    no further en after release debounces.
//  - Simultaneous: btn_load and btn_up rise same cycle -> only load pulse; up+down same cycle
//    -> only en with up=1; press down while up repeating -> ignored.
//  - Integration: drive cnt with outputs, 3 up presses from 0 -> count=3; load 4'hF then up -> 0.

Source files
------------

// File: rtl/cnt_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : cnt_ctrl_pkg                                                       |
// | Brief   : Shared command/state types and button indices for cnt_ctrl.        |
// | Rev     : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
package cnt_ctrl_pkg;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_UP,
    CMD_DOWN,
    CMD_LOAD
  } cmd_t;

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_HOLD,
    RPT_REPEAT
  } rpt_state_t;

  localparam int c_BTN_UP    = 0;
  localparam int c_BTN_DOWN  = 1;
  localparam int c_BTN_LOAD  = 2;
  localparam int c_NUM_BTN   = 3;
  localparam int c_TIMER_W   = 32;

  // Fixed priority: load beats up beats down; losers are simply dropped.
  function automatic cmd_t arbitrate(input logic i_ld, input logic i_up, input logic i_dn);
    cmd_t v_cmd;
    v_cmd = CMD_NONE;
    if (i_ld) begin
      v_cmd = CMD_LOAD;
    end else if (i_up) begin
      v_cmd = CMD_UP;
    end else if (i_dn) begin
      v_cmd = CMD_DOWN;
    end
    return v_cmd;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cnt_ctrl_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : btn_debounce                                                       |
// | Brief   : 2-flop synchronizer, counter debounce and registered rise pulse.   |
// | Rev     : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise
);

  localparam int unsigned c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 32'd1);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_level;
  logic               r_level_q;
  logic               r_rise;
  logic [c_CNT_W-1:0] r_cnt;

  logic w_mismatch;
  logic w_accept;

  assign w_mismatch = r_sync2 ^ r_level;
  assign w_accept   = w_mismatch && (r_cnt == c_CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_q <= 1'b0;
      r_rise    <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_level_q <= r_level;
      r_rise    <= r_level & ~r_level_q;
      // Counter restarts on acceptance so the next change needs a full stable run.
      if (!w_mismatch || w_accept) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_accept) begin
        r_level <= ~r_level;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;

endmodule
`default_nettype wire

// File: rtl/cnt_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : cnt_ctrl                                                           |
// | Brief   : Button/switch front end producing clean en/up/load/count_in.       |
// | Rev     : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
module cnt_ctrl
  import cnt_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned HOLD_CYCLES     = 50000000,
  parameter int unsigned REPEAT_CYCLES   = 10000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_load,
  input  logic [WIDTH-1:0] sw,
  output logic             en,
  output logic             up,
  output logic             load,
  output logic [WIDTH-1:0] count_in
);

  localparam logic [c_TIMER_W-1:0] c_HOLD_LAST = c_TIMER_W'(HOLD_CYCLES - 32'd1);
  localparam logic [c_TIMER_W-1:0] c_REP_LAST  = c_TIMER_W'(REPEAT_CYCLES - 32'd1);

  logic [c_NUM_BTN-1:0] w_raw;
  logic [c_NUM_BTN-1:0] w_level;
  logic [c_NUM_BTN-1:0] w_rise;

  assign w_raw = {btn_load, btn_down, btn_up};

  for (genvar g = 0; g < c_NUM_BTN; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db (
      .clk     (clk),
      .rst     (rst),
      .i_btn   (w_raw[g]),
      .o_level (w_level[g]),
      .o_rise  (w_rise[g])
    );
  end

  logic [WIDTH-1:0] r_sw_s1;
  logic [WIDTH-1:0] r_sw_s2;

  rpt_state_t           r_state;
  rpt_state_t           w_state_nxt;
  logic                 r_dir;
  logic                 w_dir_nxt;
  logic [c_TIMER_W-1:0] r_timer;
  logic [c_TIMER_W-1:0] w_timer_nxt;

  logic             r_en;
  logic             r_up;
  logic             r_load;
  logic [WIDTH-1:0] r_count_in;

  logic       w_en_nxt;
  logic       w_up_nxt;
  logic       w_load_nxt;
  cmd_t       w_cmd;
  logic [1:0] w_dir_idx;
  logic       w_dir_level;

  assign w_cmd       = arbitrate(w_rise[c_BTN_LOAD], w_rise[c_BTN_UP], w_rise[c_BTN_DOWN]);
  assign w_dir_idx   = r_dir ? 2'(c_BTN_UP) : 2'(c_BTN_DOWN);
  assign w_dir_level = w_level[w_dir_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RPT_IDLE;
      r_dir   <= 1'b0;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_dir   <= w_dir_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_timer_nxt = r_timer;
    w_load_nxt  = (w_cmd == CMD_LOAD);
    w_en_nxt    = 1'b0;
    w_up_nxt    = r_up;
    case (r_state)
      RPT_IDLE: begin
        if ((w_cmd == CMD_UP) || (w_cmd == CMD_DOWN)) begin
          w_en_nxt    = 1'b1;
          w_dir_nxt   = (w_cmd == CMD_UP);
          w_timer_nxt = '0;
          w_state_nxt = RPT_HOLD;
        end
      end
      RPT_HOLD: begin
        // Release of the owning button wins over any timer expiry in the same cycle.
        if (!w_dir_level) begin
          w_state_nxt = RPT_IDLE;
        end else if ((HOLD_CYCLES != 0) && (r_timer == c_HOLD_LAST)) begin
          w_en_nxt    = 1'b1;
          w_timer_nxt = '0;
          w_state_nxt = RPT_REPEAT;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      RPT_REPEAT: begin
        if (!w_dir_level) begin
          w_state_nxt = RPT_IDLE;
        end else if (r_timer == c_REP_LAST) begin
          w_en_nxt    = 1'b1;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      default: begin
        w_state_nxt = RPT_IDLE;
      end
    endcase
    // A repeat tick that lands on a load is lost; the timer has already restarted.
    if (w_load_nxt) begin
      w_en_nxt = 1'b0;
    end
    if (w_en_nxt) begin
      w_up_nxt = w_dir_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sw_s1    <= '0;
      r_sw_s2    <= '0;
      r_en       <= 1'b0;
      r_up       <= 1'b0;
      r_load     <= 1'b0;
      r_count_in <= '0;
    end else begin
      r_sw_s1 <= sw;
      r_sw_s2 <= r_sw_s1;
      r_en    <= w_en_nxt;
      r_up    <= w_up_nxt;
      r_load  <= w_load_nxt;
      if (w_load_nxt) begin
        r_count_in <= r_sw_s2;
      end
    end
  end

  assign en       = r_en;
  assign up       = r_up;
  assign load     = r_load;
  assign count_in = r_count_in;

endmodule
`default_nettype wire

// File: tb/tb_cnt_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_cnt_ctrl                                                        |
// | Brief   : Scoreboard bench for cnt_ctrl with a cycle-history reference model.|
// | Rev     : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
module tb_cnt_ctrl;

  localparam int W    = 4;
  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int REP  = 3;
  localparam int MAXC = 8192;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         btn_up = 1'b0;
  logic         btn_down = 1'b0;
  logic         btn_load = 1'b0;
  logic [W-1:0] sw = '0;
  logic         en;
  logic         up;
  logic         load;
  logic [W-1:0] count_in;

  int tests = 0;
  int fails = 0;
  int n_en = 0;
  int n_load = 0;

  always #5 clk = ~clk;

  cnt_ctrl #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (DEB),
    .HOLD_CYCLES     (HOLD),
    .REPEAT_CYCLES   (REP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_load (btn_load),
    .sw       (sw),
    .en       (en),
    .up       (up),
    .load     (load),
    .count_in (count_in)
  );

  typedef struct {
    int           cyc;
    bit           is_load;
    bit           dir;
    logic [W-1:0] cin;
  } ev_t;

  ev_t expq[$];

  // Reference model: per-cycle histories of raw samples and accepted levels.
  bit           hraw [3][MAXC];
  bit           hdb  [3][MAXC];
  bit           hrst [MAXC];
  logic [W-1:0] hsw  [MAXC];
  int           cyc = 0;
  bit           m_busy = 0;
  bit           m_dir = 0;
  int           m_next = 0;
  bit           m_up = 0;
  logic [W-1:0] m_cin = '0;

  always @(posedge clk) begin
    logic [2:0] raw;
    logic [2:0] rise;
    logic [2:0] lvl;
    bit         prev;
    bit         flip;
    bit         do_en;
    bit         do_load;
    ev_t        e;
    cyc = cyc + 1;
    if (cyc >= MAXC - 1) begin
      $display("FAIL model_overflow: cycle %0d required below %0d", cyc, MAXC - 1);
      $fatal(1, "history exhausted");
    end
    raw = {btn_load, btn_down, btn_up};
    hrst[cyc] = rst;
    hsw[cyc]  = rst ? '0 : sw;
    for (int b = 0; b < 3; b++) hraw[b][cyc] = rst ? 1'b0 : raw[b];
    if (rst) begin
      for (int b = 0; b < 3; b++) hdb[b][cyc] = 1'b0;
      m_busy = 0;
      m_up   = 0;
      m_cin  = '0;
    end else begin
      // A level is accepted once DEB consecutive synchronized samples disagree with it.
      for (int b = 0; b < 3; b++) begin
        prev = hdb[b][cyc-1];
        flip = 1;
        for (int k = 2; k <= DEB + 1; k++) begin
          if (cyc - k < 0 || hraw[b][cyc-k] == prev) flip = 0;
        end
        hdb[b][cyc] = flip ? !prev : prev;
      end
      for (int b = 0; b < 3; b++) begin
        rise[b] = !hrst[cyc-1] && hdb[b][cyc-2] && !hdb[b][cyc-3];
        lvl[b]  = hdb[b][cyc-1];
      end
      do_load = rise[2];
      do_en   = 0;
      if (!m_busy) begin
        if (!do_load && (rise[0] || rise[1])) begin
          do_en  = 1;
          m_dir  = rise[0];
          m_busy = 1;
          m_next = cyc + HOLD;
        end
      end else if (!lvl[m_dir ? 0 : 1]) begin
        m_busy = 0;
      end else if (cyc == m_next) begin
        do_en  = !do_load;
        m_next = cyc + REP;
      end
      if (do_load) begin
        m_cin     = hsw[cyc-2];
        e.cyc     = cyc;
        e.is_load = 1;
        e.dir     = m_up;
        e.cin     = m_cin;
        expq.push_back(e);
      end
      if (do_en) begin
        m_up      = m_dir;
        e.cyc     = cyc;
        e.is_load = 0;
        e.dir     = m_up;
        e.cin     = m_cin;
        expq.push_back(e);
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a command.
  always @(posedge clk) begin
    ev_t e;
    #1;
    if (en) n_en = n_en + 1;
    if (load) n_load = n_load + 1;
    if (hrst[cyc]) begin
      tests = tests + 1;
      if (en || load || up || count_in != '0) begin
        fails = fails + 1;
        $display("FAIL reset_outputs: cyc %0d en=%0b up=%0b load=%0b count_in=%h, required all 0",
                 cyc, en, up, load, count_in);
      end
    end else begin
      if (en && load) begin
        tests = tests + 1;
        fails = fails + 1;
        $display("FAIL en_load_exclusive: cyc %0d both high, required at most one", cyc);
      end
      if (en || load) begin
        tests = tests + 1;
        if (expq.size() == 0) begin
          fails = fails + 1;
          $display("FAIL unexpected_cmd: cyc %0d en=%0b load=%0b, required none", cyc, en, load);
        end else begin
          e = expq.pop_front();
          if (e.cyc != cyc || e.is_load != load || e.dir != up || e.cin != count_in) begin
            fails = fails + 1;
            $display("FAIL cmd_match: cyc %0d load=%0b up=%0b cin=%h, required cyc %0d load=%0b up=%0b cin=%h",
                     cyc, load, up, count_in, e.cyc, e.is_load, e.dir, e.cin);
          end
        end
      end else if (expq.size() > 0 && expq[0].cyc <= cyc) begin
        tests = tests + 1;
        fails = fails + 1;
        $display("FAIL missed_cmd: cyc %0d no output, required load=%0b up=%0b at cyc %0d",
                 cyc, expq[0].is_load, expq[0].dir, expq[0].cyc);
        void'(expq.pop_front());
      end
      tests = tests + 1;
      if (up !== m_up || count_in !== m_cin) begin
        fails = fails + 1;
        $display("FAIL steady_outputs: cyc %0d up=%0b count_in=%h, required up=%0b count_in=%h",
                 cyc, up, count_in, m_up, m_cin);
      end
    end
  end

  // Behavioural 4-bit up/down counter fed by the DUT outputs.
  logic [W-1:0] tb_cnt;
  always @(posedge clk) begin
    if (rst) tb_cnt <= '0;
    else if (load) tb_cnt <= count_in;
    else if (en) tb_cnt <= up ? tb_cnt + 1'b1 : tb_cnt - 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests = tests + 1;
    if (act != exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic tap_up(input int hold);
    btn_up = 1; tick(hold); btn_up = 0; tick(14);
  endtask

  int e0;
  int l0;

  initial begin
    // Reset with every button pressed, then keep btn_up held.
    rst = 1; btn_up = 1; btn_down = 1; btn_load = 1; sw = 4'h5;
    tick(4);
    e0 = n_en;
    rst = 0; btn_down = 0; btn_load = 0;
    tick(6); btn_up = 0; tick(14);
    check("reset_then_held_up_en_count", n_en - e0, 1);
    check("reset_then_held_up_dir", up, 1);

    // Glitches of 3 cycles never pass; a 6 cycle hold does.
    e0 = n_en;
    repeat (4) begin
      btn_down = 1; tick(3); btn_down = 0; tick(2);
    end
    tick(10);
    check("glitch_no_en", n_en - e0, 0);
    btn_down = 1; tick(6); btn_down = 0; tick(14);
    check("down_held_en_count", n_en - e0, 1);
    check("down_held_dir", up, 0);

    // Load preset from switches; later switch changes do not leak through.
    e0 = n_en; l0 = n_load;
    sw = 4'hA; tick(3);
    btn_load = 1; tick(10); btn_load = 0; tick(14);
    check("load_count", n_load - l0, 1);
    check("load_no_en", n_en - e0, 0);
    check("load_value", count_in, 'hA);
    sw = 4'h3; tick(10);
    check("load_value_sticky", count_in, 'hA);

    // Auto-repeat: press, +HOLD, then every REP until release is accepted.
    e0 = n_en;
    btn_up = 1; tick(30); btn_up = 0; tick(20);
    check("repeat_en_count", n_en - e0, 8);
    check("repeat_dir", up, 1);

    // Simultaneous presses.
    e0 = n_en; l0 = n_load;
    btn_load = 1; btn_up = 1; tick(6); btn_load = 0; btn_up = 0; tick(14);
    check("load_beats_up_load", n_load - l0, 1);
    check("load_beats_up_en", n_en - e0, 0);
    e0 = n_en;
    btn_down = 1; tick(2); btn_down = 0; tick(14);
    btn_up = 1; btn_down = 1; tick(6); btn_up = 0; btn_down = 0; tick(14);
    check("up_beats_down_en", n_en - e0, 1);
    check("up_beats_down_dir", up, 1);
    e0 = n_en;
    btn_up = 1; tick(10); btn_down = 1; tick(6); btn_down = 0; tick(4); btn_up = 0; tick(20);
    check("down_ignored_while_up_en", n_en - e0, 5);
    check("down_ignored_while_up_dir", up, 1);

    // Reset mid-repeat while btn_up stays held: seen as a fresh press afterwards.
    e0 = n_en;
    btn_up = 1; tick(20);
    rst = 1; tick(3); rst = 0;
    e0 = n_en;
    tick(6); btn_up = 0; tick(14);
    check("held_through_reset_en", n_en - e0, 1);

    // Integration with a counter.
    rst = 1; tick(2); rst = 0; tick(2);
    repeat (3) tap_up(6);
    check("integ_three_ups", tb_cnt, 3);
    sw = 4'hF; tick(3);
    btn_load = 1; tick(6); btn_load = 0; tick(14);
    check("integ_load_F", tb_cnt, 15);
    tap_up(6);
    check("integ_wrap_to_0", tb_cnt, 0);

    // Randomized button activity, judged by the reference model.
    for (int i = 0; i < 40; i++) begin
      sw = 4'($urandom);
      {btn_load, btn_down, btn_up} = 3'($urandom_range(1, 7));
      tick($urandom_range(1, 16));
      if ($urandom_range(0, 3) == 0) begin
        btn_up = ~btn_up;
        tick($urandom_range(1, 6));
      end
      {btn_load, btn_down, btn_up} = 3'b000;
      tick($urandom_range(0, 12));
    end
    tick(25);
    check("scoreboard_drained", expq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
